// File: rtl/bist_pkg.sv
// Shared types and helpers for the s9234 BIST sequencer / signature stage.
// Contents: FSM state enum, chain and MISR widths, busy decode, MISR step.
package bist_pkg;

    localparam int unsigned NUM_CHAINS = 7;
    localparam int unsigned MISR_W     = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } bist_state_t;

    // A run is in progress in every state other than IDLE and DONE.
    function automatic logic is_busy(input bist_state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

    // One MISR step: q[0] takes the feedback from q[6], q[i] takes q[i-1].
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0]     q,
                                                    input logic [NUM_CHAINS-1:0] d);
        return d ^ {q[MISR_W-2:0], q[MISR_W-1]};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 7-bit multiple-input signature register compacting the scan-chain outputs.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en),
//        en (compact din this cycle), din (chain outputs), sig (MISR contents).
module bist_misr
    import bist_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [NUM_CHAINS-1:0] din,
    output logic [MISR_W-1:0]     sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    // Next MISR value: clear, compact or hold.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_step(sig_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_sig_ctrl.sv
// BIST sequencer and signature stage for the 7-chain s9234 scan CUT.
// Runs NUM_PATTERNS shift/capture rounds, unloads, compacts the chain outputs
// into a MISR and compares against golden_sig.
// Ports: CK, reset_n (async active-low), start, so_chain[6:0], golden_sig[6:0]
//        -> bist_en (falling-edge registered), scan_en, tpg_reset, busy, done,
//        pass, signature[6:0].
// Optional: BIST_ABORT_EN adds input abort and output aborted.
module bist_sig_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned CHAIN_LEN    = 33,
    parameter int unsigned NUM_PATTERNS = 100
) (
    input  logic                  CK,
    input  logic                  reset_n,
    input  logic                  start,
`ifdef BIST_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    input  logic [NUM_CHAINS-1:0] so_chain,
    input  logic [MISR_W-1:0]     golden_sig,
    output logic                  bist_en,
    output logic                  scan_en,
    output logic                  tpg_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [MISR_W-1:0]     signature
);

    localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PAT_W   = $clog2(NUM_PATTERNS + 1);

    bist_state_t        state_q, state_d;
    logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
    logic               scan_en_q, scan_en_d;
    logic               tpg_reset_q, tpg_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               bist_en_q, bist_en_d;
    logic               abort_c;
    logic               last_shift_c;
    logic [PAT_W-1:0]   pat_inc_c;
    logic               misr_clr_c;
    logic               misr_en_c;

`ifdef BIST_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_c = abort && is_busy(state_q);
`else
    assign abort_c = 1'b0;
`endif

    assign last_shift_c = (shift_cnt_q == SHIFT_W'(CHAIN_LEN - 1));
    assign pat_inc_c    = pat_cnt_q + PAT_W'(1);

    // State register.
    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = '0;
        pat_cnt_d   = pat_cnt_q;
        case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT: begin
                pat_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (last_shift_c) state_d = CAPTURE;
                else              shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
            end
            CAPTURE: begin
                pat_cnt_d = pat_inc_c;
                state_d   = (pat_inc_c == PAT_W'(NUM_PATTERNS)) ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                if (last_shift_c) state_d = COMPARE;
                else              shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
            end
            COMPARE: state_d = DONE;
            DONE:    if (start) state_d = INIT;
            default: state_d = IDLE;
        endcase
        if (abort_c) begin
            state_d = DONE;
        end
    end

    // Output decode: Moore outputs from the next state, so their flops track
    // the state register; bist_en from the current state for the falling edge.
    always_comb begin
        scan_en_d   = (state_d == SHIFT) || (state_d == UNLOAD);
        tpg_reset_d = (state_d == INIT);
        busy_d      = is_busy(state_d);
        done_d      = (state_d == DONE);
        bist_en_d   = (state_q == INIT) || (state_q == SHIFT) || (state_q == UNLOAD);
        pass_d      = pass_q;
        if (state_d == INIT) begin
            pass_d = 1'b0;
        end else if (abort_c) begin
            pass_d = 1'b0;
        end else if (state_q == COMPARE) begin
            pass_d = (signature == golden_sig);
        end
`ifdef BIST_ABORT_EN
        aborted_d = aborted_q;
        if (state_d == INIT) begin
            aborted_d = 1'b0;
        end else if (abort_c) begin
            aborted_d = 1'b1;
        end
`endif
        // First SHIFT round only loads; chain contents are unknown until then.
        misr_clr_c = (state_q == INIT);
        misr_en_c  = !abort_c &&
                     (((state_q == SHIFT) && (pat_cnt_q != '0)) || (state_q == UNLOAD));
    end

    // Counters and rising-edge output registers.
    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            shift_cnt_q <= '0;
            pat_cnt_q   <= '0;
            scan_en_q   <= 1'b0;
            tpg_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
`ifdef BIST_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            shift_cnt_q <= shift_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            scan_en_q   <= scan_en_d;
            tpg_reset_q <= tpg_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
`ifdef BIST_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    // bist_en feeds an AND clock gate: change it only while CK is low.
    always_ff @(negedge CK or negedge reset_n) begin
        if (!reset_n) begin
            bist_en_q <= 1'b0;
        end else begin
            bist_en_q <= bist_en_d;
        end
    end

    bist_misr u_misr (
        .clk   (CK),
        .rst_n (reset_n),
        .clr   (misr_clr_c),
        .en    (misr_en_c),
        .din   (so_chain),
        .sig   (signature)
    );

    assign bist_en   = bist_en_q;
    assign scan_en   = scan_en_q;
    assign tpg_reset = tpg_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
`ifdef BIST_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_bist_sig_ctrl.sv
// Directed bench for bist_sig_ctrl with CHAIN_LEN=4, NUM_PATTERNS=2.
module tb_bist_sig_ctrl;

    localparam int unsigned CL       = 4;
    localparam int unsigned NP       = 2;
    localparam int          RUN_EDGE = 17;

    logic       CK = 1'b0;
    logic       reset_n;
    logic       start;
    logic [6:0] so_chain;
    logic [6:0] golden_sig;
    logic       bist_en, scan_en, tpg_reset, busy, done, pass;
    logic [6:0] signature;
`ifdef BIST_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    always #5 CK = ~CK;

    bist_sig_ctrl #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP)) dut (
        .CK         (CK),
        .reset_n    (reset_n),
        .start      (start),
`ifdef BIST_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .so_chain   (so_chain),
        .golden_sig (golden_sig),
        .bist_en    (bist_en),
        .scan_en    (scan_en),
        .tpg_reset  (tpg_reset),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // bist_en must only move while CK is low (outside reset).
    always @(bist_en) begin
        if (mon_en && reset_n === 1'b1) check("bist_en_changes_ck_low", 32'(CK), 32'd0);
    end

    // Launch a run, optionally pulse start mid-run, count edges until done.
    task automatic run_bist(input logic [6:0] so, input logic [6:0] gold,
                            input bit mid_start, output int edges);
        so_chain   = so;
        golden_sig = gold;
        @(negedge CK) start = 1'b1;
        @(posedge CK);
        edges = 1;
        #1;
        check("init_tpg_reset", 32'(tpg_reset), 32'd1);
        check("init_pass_cleared", 32'(pass), 32'd0);
        @(negedge CK) start = 1'b0;
        while (!done && edges < 200) begin
            if (mid_start && edges == 5) begin
                start = 1'b1;
                @(posedge CK);
                edges++;
                #1;
                @(negedge CK) start = 1'b0;
            end else begin
                @(posedge CK);
                edges++;
                #1;
            end
        end
    endtask

    typedef struct {
        logic [6:0] so;
        logic [6:0] golden;
        logic [6:0] exp_sig;
        logic       exp_pass;
    } vec_t;

    vec_t        vecs[6];
    int          e;
    logic [16:0] se_v, be_v, tr_v;
    logic [6:0]  sg[18];
    logic [6:0]  exp_sg[18];

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        so_chain   = '0;
        golden_sig = '0;
`ifdef BIST_ABORT_EN
        abort      = 1'b0;
`endif
        vecs[0] = '{7'h00, 7'h00, 7'h00, 1'b1};
        vecs[1] = '{7'h01, 7'h7E, 7'h7E, 1'b1};
        vecs[2] = '{7'h01, 7'h7F, 7'h7E, 1'b0};
        vecs[3] = '{7'h7F, 7'h00, 7'h00, 1'b1};
        vecs[4] = '{7'h40, 7'h3F, 7'h3F, 1'b1};
        vecs[5] = '{7'h00, 7'h01, 7'h00, 1'b0};

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_bist_en", 32'(bist_en), 32'd0);
        check("rst_scan_en", 32'(scan_en), 32'd0);
        check("rst_tpg_reset", 32'(tpg_reset), 32'd0);
        check("rst_signature", 32'(signature), 32'd0);
        @(negedge CK) reset_n = 1'b1;
        mon_en = 1'b1;

        // Table-driven full runs
        for (int i = 0; i < 6; i++) begin
            run_bist(vecs[i].so, vecs[i].golden, 1'b0, e);
            check($sformatf("v%0d_done_edge", i), 32'(e), 32'(RUN_EDGE));
            check($sformatf("v%0d_done", i), 32'(done), 32'd1);
            check($sformatf("v%0d_signature", i), 32'(signature), 32'(vecs[i].exp_sig));
            check($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
        end

        // DONE holds without start
        repeat (3) @(posedge CK);
        #1;
        check("done_hold", 32'(done), 32'd1);
        check("done_sig_hold", 32'(signature), 32'h00);
        check("done_busy_low", 32'(busy), 32'd0);

        // Cycle-by-cycle sequencing, so_chain = 1
        so_chain   = 7'h01;
        golden_sig = 7'h7E;
        exp_sg = '{default: 7'h00};
        exp_sg[8] = 7'h01; exp_sg[9] = 7'h03; exp_sg[10] = 7'h07; exp_sg[11] = 7'h0F;
        exp_sg[12] = 7'h0F; exp_sg[13] = 7'h1F; exp_sg[14] = 7'h3F; exp_sg[15] = 7'h7F;
        exp_sg[16] = 7'h7E; exp_sg[17] = 7'h7E;
        @(negedge CK) start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge CK);
            #1;
            start = 1'b0;
            se_v[k-1] = scan_en;
            tr_v[k-1] = tpg_reset;
            sg[k]     = signature;
            @(negedge CK);
            #1;
            be_v[k-1] = bist_en;
        end
        check("seq_scan_en", 32'(se_v), 32'(17'b00111101111011110));
        check("seq_bist_en", 32'(be_v), 32'(17'b00111101111011111));
        check("seq_tpg_reset", 32'(tr_v), 32'(17'b00000000000000001));
        for (int k = 2; k <= 17; k++) begin
            check($sformatf("seq_sig_c%0d", k), 32'(sg[k]), 32'(exp_sg[k]));
        end
        check("seq_pass", 32'(pass), 32'd1);

        // start pulsed mid-run is ignored; re-run from DONE clears pass at INIT
        run_bist(7'h01, 7'h7E, 1'b1, e);
        check("midstart_done_edge", 32'(e), 32'(RUN_EDGE));
        check("midstart_signature", 32'(signature), 32'h7E);
        check("midstart_pass", 32'(pass), 32'd1);

        // Reset asserted during UNLOAD
        @(negedge CK) start = 1'b1;
        @(posedge CK);
        @(negedge CK) start = 1'b0;
        repeat (12) @(posedge CK);
        @(negedge CK);
        check("unload_scan_en", 32'(scan_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_rst_busy_now", 32'(busy), 32'd0);
        check("abort_rst_sig_now", 32'(signature), 32'd0);
        @(posedge CK);
        #1;
        check("abort_rst_busy", 32'(busy), 32'd0);
        check("abort_rst_done", 32'(done), 32'd0);
        check("abort_rst_pass", 32'(pass), 32'd0);
        check("abort_rst_bist_en", 32'(bist_en), 32'd0);
        check("abort_rst_scan_en", 32'(scan_en), 32'd0);
        check("abort_rst_signature", 32'(signature), 32'd0);
        @(negedge CK) reset_n = 1'b1;
        @(posedge CK);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);

`ifdef BIST_ABORT_EN
        // abort during the second SHIFT round
        so_chain   = 7'h01;
        golden_sig = 7'h7E;
        @(negedge CK) start = 1'b1;
        @(posedge CK);
        @(negedge CK) start = 1'b0;
        repeat (7) @(posedge CK);
        @(negedge CK) abort = 1'b1;
        @(posedge CK);
        #1;
        check("ab_done", 32'(done), 32'd1);
        check("ab_aborted", 32'(aborted), 32'd1);
        check("ab_pass", 32'(pass), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_sig_frozen", 32'(signature), 32'h01);
        @(negedge CK) abort = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        check("ab_sig_hold", 32'(signature), 32'h01);
        check("ab_aborted_hold", 32'(aborted), 32'd1);
        run_bist(7'h01, 7'h7E, 1'b0, e);
        check("ab_rerun_aborted", 32'(aborted), 32'd0);
        check("ab_rerun_sig", 32'(signature), 32'h7E);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
